// File: rtl/nexus_nonce_reporter.sv
// Buffers good-nonce pulses in a small FIFO and streams each one out as a 10-byte frame: sync, 8 nonce bytes (MSB first), XOR checksum.
// Optional NONCE_REPORT_DEDUP_EN discards a nonce equal to the last one accepted.
module nexus_nonce_reporter #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] NonceIn,
  input  logic        NonceValid,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic        OvfClr,
  output logic        Overflow,
  output logic [15:0] DropCount,
  output logic        Busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;
  state_t state, nextState;

  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic [63:0] shReg;
  logic [7:0]  csum;
  logic [2:0]  byteCnt;
  logic        empty, full, xfer, pop, push, drop, dup;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign xfer  = TxValid && TxReady;
  assign Busy  = (state != IDLE) || !empty;

`ifdef NONCE_REPORT_DEDUP_EN
  logic [63:0] lastNonce;
  logic        lastVld;
  assign dup = lastVld && (NonceIn == lastNonce);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastNonce <= '0;
      lastVld   <= 1'b0;
    end else if (push) begin
      lastNonce <= NonceIn;
      lastVld   <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push = NonceValid && !dup && (!full || pop);
  assign drop = NonceValid && !dup && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (!empty) nextState = SYNC;
      SYNC: if (xfer) nextState = DATA;
      DATA: if (xfer && byteCnt == 3'd7) nextState = CSUM;
      CSUM: if (xfer) nextState = empty ? IDLE : SYNC;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      CSUM:    pop = xfer && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= NonceIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Byte datapath; TxData always holds the byte currently offered downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TxData  <= 8'h00;
      TxValid <= 1'b0;
      shReg   <= '0;
      csum    <= '0;
      byteCnt <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shReg   <= mem[rdPtr[AW-1:0]];
          csum    <= '0;
          TxData  <= SYNC_BYTE;
          TxValid <= 1'b1;
        end
        SYNC: if (xfer) begin
          TxData  <= shReg[63:56];
          shReg   <= {shReg[55:0], 8'h00};
          byteCnt <= '0;
        end
        DATA: if (xfer) begin
          csum    <= csum ^ TxData;
          byteCnt <= byteCnt + 3'd1;
          if (byteCnt == 3'd7) begin
            TxData <= csum ^ TxData;
          end else begin
            TxData <= shReg[63:56];
            shReg  <= {shReg[55:0], 8'h00};
          end
        end
        CSUM: if (xfer) begin
          if (pop) begin
            shReg  <= mem[rdPtr[AW-1:0]];
            csum   <= '0;
            TxData <= SYNC_BYTE;
          end else begin
            TxValid <= 1'b0;
          end
        end
        default: TxValid <= 1'b0;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Overflow  <= 1'b0;
      DropCount <= '0;
    end else if (drop) begin
      Overflow  <= 1'b1;
      if (OvfClr)                  DropCount <= 16'd1;
      else if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
    end else if (OvfClr) begin
      Overflow  <= 1'b0;
      DropCount <= '0;
    end
  end
endmodule

// File: doc/nexus_nonce_reporter.md
Name: nexus_nonce_reporter

Overview:
- Consumer end of the hash core's result interface (NonceOut / GoodNonceFound).
- Captures every good-nonce pulse into a small FIFO, then serializes each nonce as a 10-byte frame on a byte stream with valid/ready handshake, toward the host UART/USB bridge.
- Sits between the NexusHashTransform instances and the host transmitter.
- Owns overflow accounting so that no lost share goes unreported.

Parameters:
- FIFO_DEPTH, 4, nonce FIFO entries; must be a power of 2, minimum 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- NonceIn  in  64  nonce from the hash core; sampled when NonceValid=1
- NonceValid  in  1  single-cycle pulse per found nonce (core's GoodNonceFound)
- TxData  out  8  frame byte
- TxValid  out  1  TxData is valid
- TxReady  in  1  downstream accepts; a byte transfers on a posedge with TxValid&&TxReady
- OvfClr  in  1  synchronous clear of Overflow and DropCount
- Overflow  out  1  sticky; set when a nonce is dropped
- DropCount  out  16  dropped-nonce count, saturates at 16'hFFFF
- Busy  out  1  frame in progress or FIFO non-empty

Behaviour:
- Reset (async, any state): TxValid=0, TxData=8'h00, Overflow=0, DropCount=0, Busy=0, FIFO empty, FSM=IDLE. The reset applies even mid-frame; the partial frame is abandoned and not resumed.
- Frame format, 10 bytes: SYNC_BYTE, then nonce bytes MSB first ([63:56] .. [7:0]), then CSUM = XOR of the 8 nonce bytes.
- FIFO push: NonceValid=1 and (not full, or a pop occurs the same cycle).
  - When full with no pop, the nonce is dropped: Overflow<=1 and DropCount<=DropCount+1, saturating.
  - When OvfClr and a drop occur in the same cycle, the drop wins: Overflow=1, DropCount=1.
- FSM states: IDLE, SYNC, DATA, CSUM.
  - IDLE: when the FIFO is non-empty, pop the head into a 64-bit shift register, clear the checksum accumulator, and set TxData=SYNC_BYTE, TxValid=1. Go to SYNC.
  - SYNC: on transfer, present nonce byte 0 (MSB); clear byte counter; go to DATA.
  - DATA: on each transfer, fold the current byte into the checksum and advance. When the 8th byte transfers, present CSUM and go to CSUM.
  - CSUM: on transfer, if the FIFO is non-empty, pop the next nonce and present SYNC_BYTE with no bubble cycle (go to SYNC). Otherwise TxValid<=0 and go to IDLE.
- Handshake rules:
  - TxData/TxValid are registered.
  - While TxValid=1 and TxReady=0, TxData is held stable and TxValid is never dropped.
  - TxReady is ignored while TxValid=0.
- Latency:
  - A NonceValid sampled at edge k with an idle, empty block gives TxValid=1 / SYNC after edge k+1.
  - With TxReady held at 1, a frame takes 10 consecutive cycles.
  - Sustained throughput is 1 frame per 10 cycles.
- Capacity: FIFO_DEPTH queued nonces plus 1 in the shift register.
- Simultaneous push and pop: both occur; the count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare; pointers wrap naturally.
- Busy = (FSM!=IDLE) or FIFO non-empty.

Optional Feature:
- Macro NONCE_REPORT_DEDUP_EN.
- Defined:
  - Keep a 64-bit register of the last accepted nonce, plus a valid bit that is cleared by rst.
  - A NonceValid whose NonceIn equals that register is silently discarded. It is not pushed and not counted as a drop.
  - The register updates only on accepted pushes.
- Undefined: every NonceValid is pushed or counted as a drop, duplicates included; the logic is absent.

Test Plan:
- Single nonce: NonceIn=64'h00000001FCAFC044 pulse, TxReady=1 → TxValid after 1 cycle, bytes A5 00 00 00 01 FC AF C0 44 D6 on 10 consecutive cycles, then TxValid=0, Busy=0.
- Backpressure: same nonce; TxReady=0 for 5 cycles while byte 4 (8'h01) is presented → TxData held at 8'h01 and TxValid=1 throughout; the frame completes correctly after release.
- Overflow: FIFO_DEPTH=4, TxReady=0, 6 pulses on consecutive cycles with nonces 1..6 → nonce 6 dropped, Overflow=1, DropCount=1. Raising TxReady yields 5 back-to-back frames for nonces 1..5 with no idle cycle between them. OvfClr then gives Overflow=0, DropCount=0.
- Push while full with a pop on the same cycle: FIFO full, CSUM byte accepted on the same edge as NonceValid → push accepted, no drop, DropCount unchanged.
- Reset mid-frame: rst asserted during the DATA byte 3 transfer → TxValid=0 immediately (asynchronously), FIFO empty. A new nonce then produces a full frame starting with A5.
- With NONCE_REPORT_DEDUP_EN: two pulses of 64'h1234 → one frame only, DropCount=0. Pulses 64'h1234, 64'h5678, 64'h1234 → three frames.
